// File: rtl/hall_call_dispatcher.sv
// Hall-call dispatcher: latches floor calls, scans them round-robin and offers each to a free car (DISPATCH_NEAREST_EN: nearest free car).
// Latency: request->pending 1 cycle, pending->assign_valid 2 cycles; an offer is held stable until assign_ready.
module hall_call_dispatcher #(
  parameter int NUM_FLOORS = 12,
  parameter int NUM_ELEV   = 4
) (
  input  logic                    clk,
  input  logic                    nrst,
  input  logic [1:0]              simState,
  input  logic [NUM_FLOORS-1:0]   floorsRequested,
  input  logic [4*NUM_ELEV-1:0]   elev_floor,
  input  logic [NUM_ELEV-1:0]     elev_arrive,
  input  logic                    assign_ready,
  output logic                    assign_valid,
  output logic [1:0]              assign_elev,
  output logic [3:0]              assign_floor,
  output logic [NUM_FLOORS-1:0]   pending,
  output logic [NUM_ELEV-1:0]     reserved
);

  typedef enum logic [1:0] {IDLE, SCAN, PICK, OFFER} state_t;

  localparam logic [1:0] SIM_RUN   = 2'd1;
  localparam logic [1:0] SIM_PAUSE = 2'd2;

  state_t                state_q, state_d;
  logic [3:0]            ptr_q, ptr_d;
  logic [3:0]            floor_q, floor_d;
  logic [1:0]            elev_q, elev_d;
  logic [NUM_FLOORS-1:0] pending_q, pending_d;
  logic [NUM_ELEV-1:0]   reserved_q, reserved_d;

  logic       active;
  logic       running;
  logic       handshake;
  logic       scan_found;
  logic [3:0] scan_floor;
  logic [4:0] scan_idx;
  logic [1:0] pick_elev;

  assign running   = (simState == SIM_RUN);
  assign active    = running || (simState == SIM_PAUSE);
  // A START/ENDING cycle aborts an open offer without completing it.
  assign handshake = (state_q == OFFER) && assign_ready && active;

  always_comb begin
    scan_found = 1'b0;
    scan_floor = '0;
    scan_idx   = '0;
    for (int k = 0; k < NUM_FLOORS; k++) begin
      scan_idx = {1'b0, ptr_q} + 5'(k);
      if (scan_idx >= 5'(NUM_FLOORS)) scan_idx = scan_idx - 5'(NUM_FLOORS);
      if (!scan_found && pending_q[scan_idx[3:0]]) begin
        scan_found = 1'b1;
        scan_floor = scan_idx[3:0];
      end
    end
  end

`ifdef DISPATCH_NEAREST_EN
  logic [3:0] best_dist;
  logic [3:0] car_floor;
  logic [3:0] dist;
  logic       best_vld;

  // Strict less-than keeps the lowest index on distance ties.
  always_comb begin
    pick_elev = '0;
    best_dist = '1;
    best_vld  = 1'b0;
    car_floor = '0;
    dist      = '0;
    for (int i = 0; i < NUM_ELEV; i++) begin
      car_floor = elev_floor[4*i +: 4];
      dist = (car_floor >= floor_q) ? (car_floor - floor_q) : (floor_q - car_floor);
      if (!reserved_q[i] && (!best_vld || (dist < best_dist))) begin
        best_vld  = 1'b1;
        best_dist = dist;
        pick_elev = 2'(i);
      end
    end
  end
`else
  logic unused_elev_floor;
  assign unused_elev_floor = ^elev_floor;

  always_comb begin
    pick_elev = '0;
    for (int i = NUM_ELEV - 1; i >= 0; i--) begin
      if (!reserved_q[i]) pick_elev = 2'(i);
    end
  end
`endif

  always_comb begin
    state_d    = state_q;
    ptr_d      = ptr_q;
    floor_d    = floor_q;
    elev_d     = elev_q;
    pending_d  = pending_q;
    reserved_d = reserved_q;
    if (!active) begin
      state_d    = IDLE;
      ptr_d      = '0;
      floor_d    = '0;
      elev_d     = '0;
      pending_d  = '0;
      reserved_d = '0;
    end else begin
      // Clears are applied before sets so a coincident set wins.
      reserved_d = reserved_q & ~elev_arrive;
      if (handshake) begin
        for (int i = 0; i < NUM_FLOORS; i++) begin
          if (floor_q == 4'(i)) pending_d[i] = 1'b0;
        end
        for (int i = 0; i < NUM_ELEV; i++) begin
          if (elev_q == 2'(i)) reserved_d[i] = 1'b1;
        end
      end
      pending_d = pending_d | floorsRequested;
      case (state_q)
        IDLE: if (running) state_d = SCAN;
        SCAN: begin
          if (running && scan_found && !(&reserved_q)) begin
            floor_d = scan_floor;
            state_d = PICK;
          end
        end
        PICK: begin
          if (running) begin
            elev_d  = pick_elev;
            state_d = OFFER;
          end
        end
        OFFER: begin
          if (assign_ready) begin
            ptr_d   = (floor_q == 4'(NUM_FLOORS - 1)) ? 4'd0 : floor_q + 4'd1;
            state_d = SCAN;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      state_q    <= IDLE;
      ptr_q      <= '0;
      floor_q    <= '0;
      elev_q     <= '0;
      pending_q  <= '0;
      reserved_q <= '0;
    end else begin
      state_q    <= state_d;
      ptr_q      <= ptr_d;
      floor_q    <= floor_d;
      elev_q     <= elev_d;
      pending_q  <= pending_d;
      reserved_q <= reserved_d;
    end
  end

  assign assign_valid = (state_q == OFFER);
  assign assign_elev  = elev_q;
  assign assign_floor = floor_q;
  assign pending      = pending_q;
  assign reserved     = reserved_q;

endmodule

// File: tb/tb_hall_call_dispatcher.sv
// Directed bench for hall_call_dispatcher; expected car choices follow DISPATCH_NEAREST_EN when defined.
module tb_hall_call_dispatcher;

  localparam int NF = 12;
  localparam int NE = 4;

`ifdef DISPATCH_NEAREST_EN
  localparam int CAR_F5 = 1;
  localparam int CAR_F6 = 1;
`else
  localparam int CAR_F5 = 0;
  localparam int CAR_F6 = 0;
`endif

  logic            clk;
  logic            nrst;
  logic [1:0]      simState;
  logic [NF-1:0]   floorsRequested;
  logic [4*NE-1:0] elev_floor;
  logic [NE-1:0]   elev_arrive;
  logic            assign_ready;
  logic            assign_valid;
  logic [1:0]      assign_elev;
  logic [3:0]      assign_floor;
  logic [NF-1:0]   pending;
  logic [NE-1:0]   reserved;

  int checks = 0;
  int errors = 0;
  int rr_floor[4] = '{0, 5, 8, 9};

  hall_call_dispatcher #(.NUM_FLOORS(NF), .NUM_ELEV(NE)) dut (
    .clk(clk), .nrst(nrst), .simState(simState), .floorsRequested(floorsRequested),
    .elev_floor(elev_floor), .elev_arrive(elev_arrive), .assign_ready(assign_ready),
    .assign_valid(assign_valid), .assign_elev(assign_elev), .assign_floor(assign_floor),
    .pending(pending), .reserved(reserved)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  initial begin
    nrst = 1'b0; simState = 2'd0; floorsRequested = '0;
    elev_floor = 16'hB940; elev_arrive = '0; assign_ready = 1'b0;
    #1;
    chk("rst_valid", 32'(assign_valid), 0);
    chk("rst_elev", 32'(assign_elev), 0);
    chk("rst_floor", 32'(assign_floor), 0);
    chk("rst_pend", 32'(pending), 0);
    chk("rst_res", 32'(reserved), 0);
    step(2); nrst = 1'b1;
    step(1);
    chk("start_idle_valid", 32'(assign_valid), 0);

    // single call at floor 5
    simState = 2'd1; step(1);
    floorsRequested = 12'h020; step(1);
    floorsRequested = '0;
    chk("a_pend", 32'(pending), 'h020);
    chk("a_valid_early", 32'(assign_valid), 0);
    step(1);
    chk("a_valid_pick", 32'(assign_valid), 0);
    chk("a_floor_latched", 32'(assign_floor), 5);
    step(1);
    chk("a_valid", 32'(assign_valid), 1);
    chk("a_elev", 32'(assign_elev), CAR_F5);
    chk("a_floor", 32'(assign_floor), 5);
    step(1);
    chk("a_hold_valid", 32'(assign_valid), 1);
    chk("a_hold_elev", 32'(assign_elev), CAR_F5);
    assign_ready = 1'b1; step(1);
    assign_ready = 1'b0;
    chk("a_hs_pend", 32'(pending), 0);
    chk("a_hs_res", 32'(reserved), 32'(1 << CAR_F5));
    chk("a_hs_valid", 32'(assign_valid), 0);
    elev_arrive = 4'(1 << CAR_F5); step(1);
    elev_arrive = '0;
    chk("a_arrive_res", 32'(reserved), 0);

    // round robin from ptr=0 with ready held high
    simState = 2'd0; step(1);
    simState = 2'd1; floorsRequested = 12'h321; assign_ready = 1'b1; step(1);
    floorsRequested = '0;
    chk("b_pend", 32'(pending), 'h321);
    for (int i = 0; i < 4; i++) begin
      step(2);
      chk("b_valid", 32'(assign_valid), 1);
      chk("b_floor", 32'(assign_floor), 32'(rr_floor[i]));
      chk("b_elev", 32'(assign_elev), 32'(i));
      step(1);
      chk("b_drop", 32'(assign_valid), 0);
    end
    chk("b_pend_end", 32'(pending), 0);
    chk("b_res_end", 32'(reserved), 'hF);

    // all cars reserved, then wrap from ptr=10 once car 2 frees up
    floorsRequested = 12'h104; step(1);
    floorsRequested = '0; step(2);
    chk("c_full_valid", 32'(assign_valid), 0);
    chk("c_full_pend", 32'(pending), 'h104);
    elev_arrive = 4'b0100; step(1);
    elev_arrive = '0;
    chk("c_res", 32'(reserved), 'hB);
    chk("c_valid_wait", 32'(assign_valid), 0);
    step(2);
    chk("c_valid", 32'(assign_valid), 1);
    chk("c_elev", 32'(assign_elev), 2);
    chk("c_floor", 32'(assign_floor), 2);
    step(1);
    chk("c_hs_pend", 32'(pending), 'h100);
    chk("c_hs_res", 32'(reserved), 'hF);

    // coincident set/clear on pending and reserved
    assign_ready = 1'b0; floorsRequested = 12'h008; elev_arrive = 4'b0010; step(1);
    floorsRequested = '0; elev_arrive = '0;
    chk("d_res", 32'(reserved), 'hD);
    step(2);
    chk("d_valid", 32'(assign_valid), 1);
    chk("d_elev", 32'(assign_elev), 1);
    chk("d_floor", 32'(assign_floor), 3);
    assign_ready = 1'b1; floorsRequested = 12'h008; elev_arrive = 4'b0010; step(1);
    assign_ready = 1'b0; floorsRequested = '0; elev_arrive = '0;
    chk("d_setwin_pend", 32'(pending), 'h108);
    chk("d_setwin_res", 32'(reserved), 'hF);
    chk("d_valid_drop", 32'(assign_valid), 0);

    // PAUSE during OFFER
    elev_arrive = 4'b0001; step(1);
    elev_arrive = '0; step(2);
    chk("e_valid", 32'(assign_valid), 1);
    chk("e_floor", 32'(assign_floor), 8);
    chk("e_elev", 32'(assign_elev), 0);
    simState = 2'd2; floorsRequested = 12'h002; step(1);
    floorsRequested = '0;
    chk("e_pause_valid", 32'(assign_valid), 1);
    chk("e_pause_floor", 32'(assign_floor), 8);
    chk("e_pause_pend", 32'(pending), 'h10A);
    assign_ready = 1'b1; step(1);
    assign_ready = 1'b0;
    chk("e_hs_pend", 32'(pending), 'h00A);
    chk("e_hs_res", 32'(reserved), 'hF);
    chk("e_hs_valid", 32'(assign_valid), 0);
    elev_arrive = 4'b1000; step(1);
    elev_arrive = '0; step(1);
    chk("e_pause_scan_valid", 32'(assign_valid), 0);
    chk("e_pause_res", 32'(reserved), 'h7);

    // ENDING clears
    simState = 2'd3; step(1);
    chk("f_end_pend", 32'(pending), 0);
    chk("f_end_res", 32'(reserved), 0);
    chk("f_end_valid", 32'(assign_valid), 0);

    // async reset mid-OFFER
    simState = 2'd1; floorsRequested = 12'h040; step(1);
    floorsRequested = '0; step(2);
    chk("g_valid", 32'(assign_valid), 1);
    chk("g_floor", 32'(assign_floor), 6);
    chk("g_elev", 32'(assign_elev), CAR_F6);
    nrst = 1'b0; #2;
    chk("g_rst_valid", 32'(assign_valid), 0);
    chk("g_rst_pend", 32'(pending), 0);
    chk("g_rst_floor", 32'(assign_floor), 0);
    chk("g_rst_elev", 32'(assign_elev), 0);
    chk("g_rst_res", 32'(reserved), 0);
    step(1); nrst = 1'b1; step(4);
    chk("g_post_valid", 32'(assign_valid), 0);
    chk("g_post_pend", 32'(pending), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
